// File: rtl/systolic_mac_array.sv
// Output-stationary DIM x DIM systolic MAC array.
// A values flow left->right along rows, B values flow top->bottom along
// columns; every PE keeps one element of C = A x B in its accumulator.
// A top-level counter flags completion, and one registered row of C is read
// back per cycle.

// Single processing element: one accumulator plus the a/b forwarding registers.
module systolic_mac_pe #(
    parameter int BITS   = 8,
    parameter int BITS_C = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [BITS-1:0]   a_in,
    input  logic [BITS-1:0]   b_in,
    output logic [BITS-1:0]   a_out,
    output logic [BITS_C-1:0] acc_out,
    output logic [BITS-1:0]   b_out
);

    logic [BITS-1:0]   a_r;
    logic [BITS-1:0]   b_r;
    logic [BITS_C-1:0] acc_r;

    // Signed BITSxBITS product, sign-extended (or wrapped) to the accumulator width.
    function automatic logic [BITS_C-1:0] sext_prod(input logic [BITS-1:0] a,
                                                   input logic [BITS-1:0] b);
        logic signed [2*BITS-1:0] p;
        p = $signed(a) * $signed(b);
        return BITS_C'(p);
    endfunction

    // Accumulate and forward operands on each enabled step; hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else if (clr) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else if (en) begin
            a_r   <= a_in;
            b_r   <= b_in;
            acc_r <= acc_r + sext_prod(a_in, b_in);
        end
    end

    assign a_out   = a_r;
    assign b_out   = b_r;
    assign acc_out = acc_r;

endmodule

module systolic_mac_array #(
    parameter int DIM    = 8,
    parameter int BITS   = 8,
    parameter int BITS_C = 24,
    localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [BITS*DIM-1:0]   Ain,
    input  logic [BITS*DIM-1:0]   Bin,
    input  logic [ROW_W-1:0]      Crow,
    output logic [BITS_C*DIM-1:0] Cout,
    output logic                  done
);

    // Last product reaches PE(DIM-1,DIM-1) on step 3*DIM-3, so 3*DIM-2 steps drain the array.
    localparam int CNT_MAX = 3 * DIM - 2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [BITS-1:0]   a_s   [DIM][DIM];
    logic [BITS-1:0]   b_s   [DIM][DIM];
    logic [BITS_C-1:0] acc_s [DIM][DIM];

    logic [CNT_W-1:0]        cnt_r;
    logic                    done_r;
    logic [BITS_C*DIM-1:0]   cout_r;
    logic [BITS_C*DIM-1:0]   rd_s;

    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            logic [BITS-1:0] pe_a_s;
            logic [BITS-1:0] pe_b_s;

            if (j == 0) begin : g_a_edge
                assign pe_a_s = Ain[i*BITS +: BITS];
            end else begin : g_a_chain
                assign pe_a_s = a_s[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign pe_b_s = Bin[j*BITS +: BITS];
            end else begin : g_b_chain
                assign pe_b_s = b_s[i-1][j];
            end

            systolic_mac_pe #(
                .BITS   (BITS),
                .BITS_C (BITS_C)
            ) u_pe (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr),
                .en      (en),
                .a_in    (pe_a_s),
                .b_in    (pe_b_s),
                .a_out   (a_s[i][j]),
                .acc_out (acc_s[i][j]),
                .b_out   (b_s[i][j])
            );
        end
    end

    // Count enabled steps (saturating) and raise a sticky done on the final drain step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (en) begin
            if (cnt_r != CNT_W'(CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (cnt_r == CNT_W'(CNT_MAX - 1)) begin
                done_r <= 1'b1;
            end
        end
    end

    // Select the requested C row; rows beyond DIM read as zero.
    always_comb begin
        rd_s = '0;
        if (int'(Crow) < DIM) begin
            for (int j = 0; j < DIM; j++) begin
                rd_s[j*BITS_C +: BITS_C] = acc_s[Crow][j];
            end
        end else begin
            rd_s = '0;
        end
    end

    // Readback register runs every cycle regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_r <= '0;
        end else if (clr) begin
            cout_r <= '0;
        end else begin
            cout_r <= rd_s;
        end
    end

    assign Cout = cout_r;
    assign done = done_r;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: a 24-bit and a 16-bit accumulator
// instance share the same stimulus; expected C comes from a bench-side
// integer matrix product masked to each accumulator width.
module tb_systolic_mac_array;

    localparam int DIM = 8;

    logic               clk;
    logic               rst_n;
    logic               clr;
    logic               en;
    logic [8*DIM-1:0]   Ain;
    logic [8*DIM-1:0]   Bin;
    logic [2:0]         Crow;
    logic [24*DIM-1:0]  cout24;
    logic [16*DIM-1:0]  cout16;
    logic               done24;
    logic               done16;

    int n_checks;
    int n_fail;
    int mat_a [DIM][DIM];
    int mat_b [DIM][DIM];

    systolic_mac_array #(.DIM(DIM), .BITS(8), .BITS_C(24)) u_dut (
        .clk (clk), .rst_n (rst_n), .clr (clr), .en (en),
        .Ain (Ain), .Bin (Bin), .Crow (Crow), .Cout (cout24), .done (done24)
    );

    systolic_mac_array #(.DIM(DIM), .BITS(8), .BITS_C(16)) u_dut16 (
        .clk (clk), .rst_n (rst_n), .clr (clr), .en (en),
        .Ain (Ain), .Bin (Bin), .Crow (Crow), .Cout (cout16), .done (done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int golden(input int r, input int c);
        int s;
        s = 0;
        for (int k = 0; k < DIM; k++) s += mat_a[r][k] * mat_b[k][c];
        return s;
    endfunction

    // Drive skewed operands for step t (zero outside the matrix).
    task automatic drive_step(input int t);
        for (int i = 0; i < DIM; i++) begin
            int k;
            logic [31:0] va;
            logic [31:0] vb;
            k = t - i;
            va = (k >= 0 && k < DIM) ? mat_a[i][k] : 0;
            vb = (k >= 0 && k < DIM) ? mat_b[k][i] : 0;
            Ain[i*8 +: 8] = va[7:0];
            Bin[i*8 +: 8] = vb[7:0];
        end
    endtask

    // Feed steps t_lo..t_hi-1; with stall set, random en-low cycles carry junk.
    task automatic feed(input int t_lo, input int t_hi, input bit stall);
        int t;
        t = t_lo;
        while (t < t_hi) begin
            @(negedge clk);
            if (stall && ($urandom_range(0, 1) == 1)) begin
                en  = 1'b0;
                Ain = {$urandom, $urandom};
                Bin = {$urandom, $urandom};
            end else begin
                en = 1'b1;
                drive_step(t);
                t++;
            end
        end
        @(negedge clk);
        en  = 1'b0;
        Ain = '0;
        Bin = '0;
    endtask

    // Read every row of C from both instances and compare with the golden product.
    task automatic check_c(input string tag);
        for (int r = 0; r < DIM; r++) begin
            @(negedge clk);
            Crow = 3'(r);
            @(negedge clk);
            for (int j = 0; j < DIM; j++) begin
                logic [31:0] g;
                g = golden(r, j);
                check_val({tag, "_c24"}, {8'h00, cout24[j*24 +: 24]}, {8'h00, g[23:0]});
                check_val({tag, "_c16"}, {16'h0000, cout16[j*16 +: 16]}, {16'h0000, g[15:0]});
            end
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic fill(input int va, input int vb);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = va;
                mat_b[i][j] = vb;
            end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        en    = 1'b0;
        Ain   = '0;
        Bin   = '0;
        Crow  = 3'd0;
        repeat (2) @(negedge clk);
        check_val("reset_cout", {8'h00, cout24[23:0]}, 32'h0);
        check_val("reset_done", {31'h0, done24}, 32'h0);
        rst_n = 1'b1;

        // Identity A, B[k][j] = 8k+j: done only after the 22nd step.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = (i == j) ? 1 : 0;
                mat_b[i][j] = i * 8 + j;
            end
        feed(0, 21, 1'b0);
        check_val("ident_done_21", {31'h0, done24}, 32'h0);
        feed(21, 22, 1'b0);
        check_val("ident_done_22", {31'h0, done24}, 32'h1);
        check_val("ident_done16", {31'h0, done16}, 32'h1);
        check_c("ident");

        // Signed extremes: 8*16384 and 8*16129, wrapped in the 16-bit instance.
        do_clr();
        fill(-128, -128);
        feed(0, 22, 1'b0);
        check_val("neg_hand24", {8'h00, cout24[23:0]}, 32'd131072);
        check_val("neg_hand16", {16'h0, cout16[15:0]}, 32'd0);
        check_c("neg");
        do_clr();
        fill(127, 127);
        feed(0, 22, 1'b0);
        check_val("pos_hand24", {8'h00, cout24[23:0]}, 32'd129032);
        check_val("pos_hand16", {16'h0, cout16[15:0]}, 32'd63496);
        check_c("pos");

        // Random matrices with random stalls.
        do_clr();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = int'($urandom_range(0, 255)) - 128;
                mat_b[i][j] = int'($urandom_range(0, 255)) - 128;
            end
        feed(0, 21, 1'b1);
        check_val("stall_done_21", {31'h0, done24}, 32'h0);
        feed(21, 22, 1'b1);
        check_val("stall_done_22", {31'h0, done24}, 32'h1);
        check_c("stall");

        // clr mid-run with en high wins, then a full rerun.
        do_clr();
        Crow = 3'd1;
        feed(0, 10, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        en  = 1'b1;
        drive_step(10);
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b0;
        Ain = '0;
        Bin = '0;
        check_val("clr_cout", {8'h00, cout24[23:0]}, 32'h0);
        check_val("clr_done", {31'h0, done24}, 32'h0);
        @(negedge clk);
        check_val("clr_cout_next", {8'h00, cout24[23:0]}, 32'h0);
        feed(0, 22, 1'b0);
        check_c("clr_rerun");

        // Async reset between edges clears outputs before the next edge.
        do_clr();
        Crow = 3'd1;
        feed(0, 15, 1'b0);
        check_val("pre_rst_nonzero", {31'h0, (cout24 != '0)}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_cout", {8'h00, cout24[23:0]}, 32'h0);
        check_val("arst_cout_any", {31'h0, (cout24 != '0)}, 32'h0);
        check_val("arst_done", {31'h0, done24}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        feed(0, 22, 1'b0);
        check_val("arst_rerun_done", {31'h0, done24}, 32'h1);
        check_c("arst_rerun");

        // Extra zero steps after done: sticky done, C unchanged.
        feed(22, 25, 1'b0);
        check_val("post_done", {31'h0, done24}, 32'h1);

        // Readback sweep with en low: Cout follows Crow one cycle later.
        @(negedge clk);
        Crow = 3'd7;
        for (int r = 0; r < DIM; r++) begin
            @(negedge clk);
            for (int j = 0; j < DIM; j++) begin
                logic [31:0] g;
                g = golden((r + 7) % DIM, j);
                check_val("sweep_lag", {8'h00, cout24[j*24 +: 24]}, {8'h00, g[23:0]});
            end
            Crow = 3'(r);
        end
        @(negedge clk);
        begin
            logic [31:0] g;
            g = golden(7, 0);
            check_val("sweep_last", {8'h00, cout24[23:0]}, {8'h00, g[23:0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
